// File: rtl/hzd_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hzd_pkg;

    localparam int REG_ADDR_W = 5;

    // One in-flight writer: valid marks a real instruction, rd is its destination.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
    } sb_entry_t;

    // Per-cycle pipeline control decision.
    typedef enum logic [1:0] {
        DEC_PASS  = 2'd0,
        DEC_STALL = 2'd1,
        DEC_FLUSH = 2'd2
    } hzd_dec_t;

    // x0 is hardwired to zero, so it never carries a dependency.
    function automatic logic addr_is_zero(input logic [REG_ADDR_W-1:0] addr);
        return (addr == {REG_ADDR_W{1'b0}});
    endfunction

endpackage

// File: rtl/hzd_scoreboard.sv
// Shift scoreboard of in-flight destination registers ([0]=EX, [1]=MEM, [2]=WB)
// plus the two RAW match comparators for the ID source operands.
module hzd_scoreboard
    import hzd_pkg::*;
#(
    parameter int SB_DEPTH    = 3,
    parameter int CHECK_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [REG_ADDR_W-1:0] push_rd,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  hit1,
    output logic                  hit2
);

    sb_entry_t [SB_DEPTH-1:0] sb_r;
    logic                     hit1_s;
    logic                     hit2_s;

    // Advance the scoreboard one stage per cycle; non-issuing cycles enter as bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_r <= '0;
        end else begin
            sb_r[0] <= push ? sb_entry_t'{valid: 1'b1, rd: push_rd} : sb_entry_t'('0);
            for (int i = 0; i < SB_DEPTH - 1; i++) begin
                sb_r[i+1] <= sb_r[i];
            end
        end
    end

    // Compare both source operands against the checked entries; x0 never matches.
    always_comb begin
        hit1_s = 1'b0;
        hit2_s = 1'b0;
        for (int i = 0; i < CHECK_DEPTH; i++) begin
            hit1_s = hit1_s | (sb_r[i].valid & (sb_r[i].rd == rs1));
            hit2_s = hit2_s | (sb_r[i].valid & (sb_r[i].rd == rs2));
        end
        hit1_s = hit1_s & ~addr_is_zero(rs1);
        hit2_s = hit2_s & ~addr_is_zero(rs2);
    end

    assign hit1 = hit1_s;
    assign hit2 = hit2_s;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage in-order pipeline (no forwarding).
// Priority: redirect flush > RAW stall > pass. Control outputs are combinational.
module hazard_ctrl
    import hzd_pkg::*;
#(
    parameter int SB_DEPTH    = 3,
    parameter int CHECK_DEPTH = 3,
    parameter int CNT_W       = 32
) (
    input  logic                  clk_HZD,
    input  logic                  rst_HZD,
    input  logic                  valid_ID_HZD,
    input  logic [REG_ADDR_W-1:0] rs1_addr_HZD,
    input  logic                  rs1_used_HZD,
    input  logic [REG_ADDR_W-1:0] rs2_addr_HZD,
    input  logic                  rs2_used_HZD,
    input  logic [REG_ADDR_W-1:0] rd_addr_HZD,
    input  logic                  RegWrite_HZD,
    input  logic                  redirect_HZD,
    output logic                  PC_en_HZD,
    output logic                  en_IFID_HZD,
    output logic                  NOP_IFID_HZD,
    output logic                  en_IDEX_HZD,
    output logic                  NOP_IDEX_HZD,
    output logic [CNT_W-1:0]      stall_cnt_HZD,
    output logic [CNT_W-1:0]      flush_cnt_HZD
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             hit1_s;
    logic             hit2_s;
    logic             raw_s;
    logic             issue_s;
    hzd_dec_t         dec_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    // Only writers that actually leave ID with a non-zero rd enter the scoreboard.
    assign issue_s = valid_ID_HZD & (dec_s == DEC_PASS) & RegWrite_HZD & ~addr_is_zero(rd_addr_HZD);

    hzd_scoreboard #(
        .SB_DEPTH    (SB_DEPTH),
        .CHECK_DEPTH (CHECK_DEPTH)
    ) u_sb (
        .clk     (clk_HZD),
        .rst     (rst_HZD),
        .push    (issue_s),
        .push_rd (rd_addr_HZD),
        .rs1     (rs1_addr_HZD),
        .rs2     (rs2_addr_HZD),
        .hit1    (hit1_s),
        .hit2    (hit2_s)
    );

    assign raw_s = valid_ID_HZD & ((rs1_used_HZD & hit1_s) | (rs2_used_HZD & hit2_s));

    // Resolve the cycle's decision with redirect taking precedence over RAW.
    always_comb begin
        if (redirect_HZD) begin
            dec_s = DEC_FLUSH;
        end else if (raw_s) begin
            dec_s = DEC_STALL;
        end else begin
            dec_s = DEC_PASS;
        end
    end

    // Map the decision onto register enables/squashes; reset forces both stages to NOP.
    always_comb begin
        PC_en_HZD    = 1'b1;
        en_IFID_HZD  = 1'b1;
        NOP_IFID_HZD = 1'b0;
        en_IDEX_HZD  = 1'b1;
        NOP_IDEX_HZD = 1'b0;
        if (rst_HZD) begin
            PC_en_HZD    = 1'b0;
            NOP_IFID_HZD = 1'b1;
            NOP_IDEX_HZD = 1'b1;
        end else begin
            case (dec_s)
                DEC_FLUSH: begin
                    NOP_IFID_HZD = 1'b1;
                    NOP_IDEX_HZD = 1'b1;
                end
                DEC_STALL: begin
                    PC_en_HZD    = 1'b0;
                    en_IFID_HZD  = 1'b0;
                    NOP_IDEX_HZD = 1'b1;
                end
                DEC_PASS: begin
                    NOP_IDEX_HZD = 1'b0;
                end
                default: begin
                    PC_en_HZD    = 1'b0;
                    NOP_IFID_HZD = 1'b1;
                    NOP_IDEX_HZD = 1'b1;
                end
            endcase
        end
    end

    // Saturating event counters: stalls exclude cycles that were flushed instead.
    always_ff @(posedge clk_HZD) begin
        if (rst_HZD) begin
            stall_cnt_r <= '0;
            flush_cnt_r <= '0;
        end else begin
            if ((dec_s == DEC_STALL) && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if ((dec_s == DEC_FLUSH) && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign stall_cnt_HZD = stall_cnt_r;
    assign flush_cnt_HZD = flush_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (narrow counters so saturation is reachable).
module tb_hazard_ctrl;

    localparam int CNT_W = 4;

    // {PC_en, en_IFID, NOP_IFID, en_IDEX, NOP_IDEX}
    localparam logic [4:0] PASS_V  = 5'b11010;
    localparam logic [4:0] STALL_V = 5'b00011;
    localparam logic [4:0] FLUSH_V = 5'b11111;
    localparam logic [4:0] RST_V   = 5'b01111;

    logic             clk;
    logic             rst;
    logic             valid_id;
    logic [4:0]       rs1;
    logic             rs1_used;
    logic [4:0]       rs2;
    logic             rs2_used;
    logic [4:0]       rd;
    logic             reg_write;
    logic             redirect;
    logic             pc_en;
    logic             en_ifid;
    logic             nop_ifid;
    logic             en_idex;
    logic             nop_idex;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [4:0]       ctl;

    int checks;
    int errors;

    hazard_ctrl #(
        .SB_DEPTH    (3),
        .CHECK_DEPTH (3),
        .CNT_W       (CNT_W)
    ) dut (
        .clk_HZD       (clk),
        .rst_HZD       (rst),
        .valid_ID_HZD  (valid_id),
        .rs1_addr_HZD  (rs1),
        .rs1_used_HZD  (rs1_used),
        .rs2_addr_HZD  (rs2),
        .rs2_used_HZD  (rs2_used),
        .rd_addr_HZD   (rd),
        .RegWrite_HZD  (reg_write),
        .redirect_HZD  (redirect),
        .PC_en_HZD     (pc_en),
        .en_IFID_HZD   (en_ifid),
        .NOP_IFID_HZD  (nop_ifid),
        .en_IDEX_HZD   (en_idex),
        .NOP_IDEX_HZD  (nop_idex),
        .stall_cnt_HZD (stall_cnt),
        .flush_cnt_HZD (flush_cnt)
    );

    assign ctl = {pc_en, en_ifid, nop_ifid, en_idex, nop_idex};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] a1, input logic u1,
                         input logic [4:0] a2, input logic u2, input logic [4:0] d,
                         input logic w, input logic rdr);
        valid_id  = v;
        rs1       = a1;
        rs1_used  = u1;
        rs2       = a2;
        rs2_used  = u2;
        rd        = d;
        reg_write = w;
        redirect  = rdr;
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clk    = 1'b0;
        rst    = 1'b1;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);

        // Reset state
        check("rst_ctl", 32'(ctl), 32'(RST_V));
        tick();
        tick();
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        check("rst_flush_cnt", 32'(flush_cnt), 32'd0);
        rst = 1'b0;

        // Test 1: addi x5 then add x6,x5,x0 -> 3 stall cycles
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        check("t1_writer_pass", 32'(ctl), 32'(PASS_V));
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("t1_stall_ctl", 32'(ctl), 32'(STALL_V));
            tick();
        end
        check("t1_release_ctl", 32'(ctl), 32'(PASS_V));
        check("t1_stall_cnt", 32'(stall_cnt), 32'd3);
        tick();
        check("t1_sb0_rd6", 32'({dut.u_sb.sb_r[0].valid, dut.u_sb.sb_r[0].rd}), 32'h26);
        idle(3);

        // Test 2: writer of x0 never enters scoreboard; reader of x0 never stalls
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        check("t2_writer_pass", 32'(ctl), 32'(PASS_V));
        tick();
        check("t2_sb0_valid", 32'(dut.u_sb.sb_r[0].valid), 32'd0);
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd8, 1'b0, 1'b0);
        check("t2_reader_pass", 32'(ctl), 32'(PASS_V));
        tick();
        check("t2_stall_cnt", 32'(stall_cnt), 32'd3);
        idle(3);

        // Test 3: RAW and redirect in the same cycle -> flush only
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
        check("t3_flush_ctl", 32'(ctl), 32'(FLUSH_V));
        tick();
        check("t3_flush_cnt", 32'(flush_cnt), 32'd1);
        check("t3_stall_cnt", 32'(stall_cnt), 32'd3);
        check("t3_sb0_valid", 32'(dut.u_sb.sb_r[0].valid), 32'd0);
        idle(3);

        // Test 4: independent writers x1,x2,x3 then reader of x4
        for (int r = 1; r <= 3; r++) begin
            drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'(r), 1'b1, 1'b0);
            check("t4_writer_pass", 32'(ctl), 32'(PASS_V));
            tick();
        end
        drive(1'b1, 5'd4, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0);
        check("t4_reader_pass", 32'(ctl), 32'(PASS_V));
        check("t4_sb_rds", 32'({dut.u_sb.sb_r[0].rd, dut.u_sb.sb_r[1].rd, dut.u_sb.sb_r[2].rd}), 32'h0C41);
        drive(1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0);
        check("t4_mem_hit_stall", 32'(ctl), 32'(STALL_V));
        idle(3);

        // Test 5: reset during the 2nd stall cycle
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        check("t5_stall1_ctl", 32'(ctl), 32'(STALL_V));
        tick();
        rst = 1'b1;
        #1;
        check("t5_rst_ctl", 32'(ctl), 32'(RST_V));
        tick();
        rst = 1'b0;
        #1;
        check("t5_stall_cnt", 32'(stall_cnt), 32'd0);
        check("t5_flush_cnt", 32'(flush_cnt), 32'd0);
        check("t5_sb_empty", 32'({dut.u_sb.sb_r[0].valid, dut.u_sb.sb_r[1].valid, dut.u_sb.sb_r[2].valid}), 32'd0);
        check("t5_after_rst_pass", 32'(ctl), 32'(PASS_V));
        tick();
        check("t5_reader_issued", 32'({dut.u_sb.sb_r[0].valid, dut.u_sb.sb_r[0].rd}), 32'h26);
        idle(3);

        // Test 6: drive stall counter to all-ones, then one more stall holds it
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
            tick();
            drive(1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0);
            tick();
            tick();
            tick();
            tick();
        end
        check("t6_cnt_full", 32'(stall_cnt), 32'hF);
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0);
        check("t6_extra_stall", 32'(ctl), 32'(STALL_V));
        tick();
        check("t6_cnt_hold", 32'(stall_cnt), 32'hF);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
